// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the rv32i pipeline control blocks (hazard and forwarding units).
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hz_state_e;

    // Architectural zero register: never a real producer.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Width of the load-use bubble counter (covers up to 3 bubbles).
    localparam int unsigned LCNT_W = 2;

endpackage

// File: rtl/pipeline_hazard_ctrl_stall_counter.sv
// Saturating stall-cycle counter with synchronous clear.
module hazard_stall_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Clear wins over increment; increment stops at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage rv32i pipeline.
// Priority: data-memory wait > EX redirect > load-use interlock.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             cnt_clr,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             stall_idex,
    output logic             flush_idex,
    output logic             stall_exmem,
    output logic             flush_memwb,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(LOAD_STALL_CYCLES - 1);

    hz_state_e         state, state_n;
    logic [LCNT_W-1:0] lcnt, lcnt_n;
    logic              saved_ls, saved_ls_n;
    logic              hz_mem, hz_redir, hz_lu, in_ls;

    assign hz_mem   = mem_req & ~mem_ack;
    assign hz_redir = ex_valid & ex_redirect;
    assign hz_lu    = ex_valid & ex_is_load & (ex_rd != REG_X0) & id_valid &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

    // A memory wait that interrupted LOAD_STALL resumes it on the ack cycle.
    assign in_ls = (state == LOAD_STALL) | ((state == MEM_WAIT) & saved_ls);

    // Next-state and control outputs; outputs forced low while in reset.
    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        flush_ifid  = 1'b0;
        stall_idex  = 1'b0;
        flush_idex  = 1'b0;
        stall_exmem = 1'b0;
        flush_memwb = 1'b0;
        state_n     = RUN;
        lcnt_n      = lcnt;
        saved_ls_n  = 1'b0;

        if (hz_mem) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            flush_memwb = 1'b1;
            state_n     = MEM_WAIT;
            saved_ls_n  = (state == MEM_WAIT) ? saved_ls : (state == LOAD_STALL);
        end else if (hz_redir) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            lcnt_n     = '0;
        end else if (in_ls) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
            if (lcnt > LCNT_W'(1)) begin
                lcnt_n  = lcnt - LCNT_W'(1);
                state_n = LOAD_STALL;
            end else begin
                lcnt_n  = '0;
            end
        end else if (hz_lu) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
            lcnt_n     = LCNT_INIT;
            state_n    = (LCNT_INIT == '0) ? RUN : LOAD_STALL;
        end

        if (!rst_n) begin
            stall_pc    = 1'b0;
            stall_ifid  = 1'b0;
            flush_ifid  = 1'b0;
            stall_idex  = 1'b0;
            flush_idex  = 1'b0;
            stall_exmem = 1'b0;
            flush_memwb = 1'b0;
        end
    end

    // FSM state, bubble counter and interrupted-load-stall flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            lcnt     <= '0;
            saved_ls <= 1'b0;
        end else begin
            state    <= state_n;
            lcnt     <= lcnt_n;
            saved_ls <= saved_ls_n;
        end
    end

    assign state_o = state;

    hazard_stall_counter #(
        .CNT_W(CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (stall_pc),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (three parameterisations).
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_valid, ex_is_load, ex_redirect, mem_req, mem_ack, cnt_clr;

    logic        sp1, si1, fi1, sx1, fx1, sm1, fw1;
    logic        sp2, si2, fi2, sx2, fx2, sm2, fw2;
    logic        sp3, si3, fi3, sx3, fx3, sm3, fw3;
    logic [1:0]  st1, st2, st3;
    logic [31:0] cnt1, cnt2;
    logic [1:0]  cnt3;
    logic [8:0]  got1, got2, got3;

    assign got1 = {st1, sp1, si1, fi1, sx1, fx1, sm1, fw1};
    assign got2 = {st2, sp2, si2, fi2, sx2, fx2, sm2, fw2};
    assign got3 = {st3, sp3, si3, fi3, sx3, fx3, sm3, fw3};

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ack(mem_ack), .cnt_clr(cnt_clr),
        .stall_pc(sp1), .stall_ifid(si1), .flush_ifid(fi1), .stall_idex(sx1),
        .flush_idex(fx1), .stall_exmem(sm1), .flush_memwb(fw1), .state_o(st1),
        .stall_cycles(cnt1));

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .CNT_W(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ack(mem_ack), .cnt_clr(cnt_clr),
        .stall_pc(sp2), .stall_ifid(si2), .flush_ifid(fi2), .stall_idex(sx2),
        .flush_idex(fx2), .stall_exmem(sm2), .flush_memwb(fw2), .state_o(st2),
        .stall_cycles(cnt2));

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ack(mem_ack), .cnt_clr(cnt_clr),
        .stall_pc(sp3), .stall_ifid(si3), .flush_ifid(fi3), .stall_idex(sx3),
        .flush_idex(fx3), .stall_exmem(sm3), .flush_memwb(fw3), .state_o(st3),
        .stall_cycles(cnt3));

    // Output packing: {stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex, stall_exmem, flush_memwb}
    localparam logic [6:0] O_N   = 7'b0000000;
    localparam logic [6:0] O_LU  = 7'b1100100;
    localparam logic [6:0] O_RED = 7'b0010100;
    localparam logic [6:0] O_MEM = 7'b1101011;
    localparam logic [1:0] S_R   = 2'd0;
    localparam logic [1:0] S_LS  = 2'd1;
    localparam logic [1:0] S_MW  = 2'd2;

    typedef struct {
        logic       iv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       exv;
        logic       ld;
        logic [4:0] rd;
        logic       red;
        logic       mreq;
        logic       mack;
        logic [8:0] exp1;
        logic [8:0] exp2;
        int unsigned c1;
        int unsigned c2;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic exv, input logic ld,
                       input logic [4:0] rd, input logic red, input logic mreq, input logic mack,
                       input logic [8:0] e1, input logic [8:0] e2,
                       input int unsigned c1, input int unsigned c2);
        vec_t v;
        v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.exv = exv; v.ld = ld; v.rd = rd; v.red = red; v.mreq = mreq; v.mack = mack;
        v.exp1 = e1; v.exp2 = e2; v.c1 = c1; v.c2 = c2;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        //  iv rs1 rs2 u1 u2 exv ld rd red mrq mak  exp dut1 (L=1)  exp dut2 (L=2)  cnt1 cnt2
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, {S_R, O_N},   {S_R, O_N},   0, 0);  // idle
        add(1, 5, 1, 1, 0, 1, 1, 5, 0, 0, 0, {S_R, O_LU},  {S_R, O_LU},  0, 0);  // lw x5 / add x6,x5,x1
        add(1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, {S_R, O_N},   {S_LS, O_LU}, 1, 1);  // bubble in EX
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, {S_R, O_N},   {S_R, O_N},   1, 2);
        add(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, {S_R, O_N},   {S_R, O_N},   1, 2);  // lw x0, reads x0
        add(1, 5, 7, 0, 1, 1, 1, 5, 0, 0, 0, {S_R, O_N},   {S_R, O_N},   1, 2);  // rs1 match unused
        add(1, 3, 5, 1, 1, 1, 1, 5, 0, 0, 0, {S_R, O_LU},  {S_R, O_LU},  1, 2);  // rs2 match
        add(1, 3, 5, 1, 1, 0, 0, 0, 0, 0, 0, {S_R, O_N},   {S_LS, O_LU}, 2, 3);
        add(0, 5, 0, 1, 0, 1, 1, 5, 0, 0, 0, {S_R, O_N},   {S_R, O_N},   2, 4);  // ID not valid
        add(1, 1, 2, 1, 1, 1, 0, 0, 1, 0, 0, {S_R, O_RED}, {S_R, O_RED}, 2, 4);  // taken branch
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, {S_R, O_N},   {S_R, O_N},   2, 4);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, {S_R, O_N},   {S_R, O_N},   2, 4);  // redirect, EX invalid
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, {S_R, O_MEM}, {S_R, O_MEM}, 2, 4);  // mem wait + branch
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, {S_MW, O_MEM},{S_MW, O_MEM},3, 5);
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, {S_MW, O_MEM},{S_MW, O_MEM},4, 6);
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, {S_MW, O_RED},{S_MW, O_RED},5, 7);  // ack: branch kept
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, {S_R, O_N},   {S_R, O_N},   5, 7);
        add(1, 5, 0, 1, 0, 1, 1, 5, 0, 0, 0, {S_R, O_LU},  {S_R, O_LU},  5, 7);  // load-use again
        add(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0, {S_R, O_MEM}, {S_LS, O_MEM},6, 8);  // wait interrupts LS
        add(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0, {S_MW, O_MEM},{S_MW, O_MEM},7, 9);
        add(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 1, {S_MW, O_N},  {S_MW, O_LU}, 8, 10); // resumed bubble
        add(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, {S_R, O_N},   {S_R, O_N},   8, 11);

        // Reset state
        @(negedge clk);
        #2;
        chk("reset_out1", 32'(got1), 32'd0);
        chk("reset_out2", 32'(got2), 32'd0);
        chk("reset_cnt1", cnt1, 32'd0);
        chk("reset_cnt2", cnt2, 32'd0);
        rst_n = 1'b1;

        // Table vectors, one per cycle, checked mid-low-phase
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            id_valid = vecs[i].iv; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_valid = vecs[i].exv; ex_is_load = vecs[i].ld; ex_rd = vecs[i].rd;
            ex_redirect = vecs[i].red; mem_req = vecs[i].mreq; mem_ack = vecs[i].mack;
            #2;
            chk($sformatf("vec%0d_out1", i), 32'(got1), 32'(vecs[i].exp1));
            chk($sformatf("vec%0d_out2", i), 32'(got2), 32'(vecs[i].exp2));
            chk($sformatf("vec%0d_cnt1", i), cnt1, vecs[i].c1);
            chk($sformatf("vec%0d_cnt2", i), cnt2, vecs[i].c2);
        end

        // Clear beats increment in the same cycle
        @(negedge clk);
        idle_inputs();
        mem_req = 1'b1;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #2;
        chk("clr_cnt1", cnt1, 32'd0);
        chk("clr_cnt2", cnt2, 32'd0);
        chk("clr_state1", 32'(st1), 32'(S_MW));
        @(negedge clk);
        #2;
        chk("post_clr_cnt1", cnt1, 32'd1);

        // Reset in the middle of a memory wait
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("rst_wait_out1", 32'(got1[6:0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_req = 1'b0;
        #2;
        chk("rst_wait_state_out1", 32'(got1), 32'd0);
        chk("rst_wait_state_out2", 32'(got2), 32'd0);
        chk("rst_wait_state_out3", 32'(got3), 32'd0);
        chk("rst_wait_cnt1", cnt1, 32'd0);
        chk("rst_wait_cnt3", 32'(cnt3), 32'd0);

        // Saturation on the 2-bit counter
        @(negedge clk);
        mem_req = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        chk("sat_cnt3", 32'(cnt3), 32'd3);
        chk("sat_cnt1", cnt1, 32'd5);
        chk("sat_state1", 32'(st1), 32'(S_MW));
        mem_ack = 1'b1;
        @(negedge clk);
        idle_inputs();
        #2;
        chk("final_out1", 32'(got1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
